// File: rtl/rotary_position_counter.sv
// Bounded position counter driven by rotary-encoder detent pulses.
// Supports saturate or wrap at the range ends, velocity acceleration and a synchronous preload.
module rotary_position_counter #(
    parameter int WIDTH        = 8,
    parameter int MIN_VAL      = 0,
    parameter int MAX_VAL      = 255,
    parameter int WRAP         = 0,
    parameter int ACCEL_WINDOW = 1000000,
    parameter int ACCEL_STEP   = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cnt,
    input  logic             i_cnt_cw,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_pos,
    output logic             o_changed,
    output logic             o_dir,
    output logic             o_at_min,
    output logic             o_at_max
);
    localparam int XW = WIDTH + 2;
    localparam int TW = $clog2(ACCEL_WINDOW + 1);

    localparam logic [XW-1:0] MIN_X  = XW'(MIN_VAL);
    localparam logic [XW-1:0] MAX_X  = XW'(MAX_VAL);
    localparam logic [XW-1:0] SPAN_X = XW'(MAX_VAL - MIN_VAL + 1);
    localparam logic [XW-1:0] ACC_X  = XW'(ACCEL_STEP);
    localparam logic [TW-1:0] WIN    = TW'(ACCEL_WINDOW);

    typedef enum logic {SLOW, FAST} speed_t;

    speed_t          state, state_nxt;
    logic [TW-1:0]   timer;
    logic            detent, qualify;
    logic [XW-1:0]   pos_x, step_x, up_x, dn_x, load_x, res_x;
    logic [WIDTH-1:0] pos_nxt;

    always_comb begin
        state_nxt = state;
        detent    = i_cnt && !i_load;   // load wins over a coincident detent
        qualify   = (timer < WIN) && (i_cnt_cw == o_dir);

        case (state)
            SLOW: if (detent && qualify) state_nxt = FAST;
            FAST: if (i_load || (timer == WIN) || (detent && !qualify)) state_nxt = SLOW;
        endcase

        // A qualifying detent steps fast both on the SLOW->FAST edge and while FAST.
        step_x = (detent && qualify) ? ACC_X : XW'(1);
        pos_x  = XW'(o_pos);

        up_x = pos_x + step_x;
        if (up_x > MAX_X)
            up_x = (WRAP != 0) ? up_x - SPAN_X : MAX_X;

        if (pos_x < MIN_X + step_x)
            dn_x = (WRAP != 0) ? pos_x + SPAN_X - step_x : MIN_X;
        else
            dn_x = pos_x - step_x;

        load_x = XW'(i_load_val);
        if (load_x < MIN_X)      load_x = MIN_X;
        else if (load_x > MAX_X) load_x = MAX_X;

        res_x = pos_x;
        if (i_load)      res_x = load_x;
        else if (detent) res_x = i_cnt_cw ? up_x : dn_x;
        pos_nxt = res_x[WIDTH-1:0];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_pos     <= WIDTH'(MIN_VAL);
            o_changed <= 1'b0;
            o_dir     <= 1'b0;
            o_at_min  <= 1'b1;
            o_at_max  <= 1'b0;
            timer     <= WIN;
            state     <= SLOW;
        end else begin
            o_pos     <= pos_nxt;
            o_changed <= (pos_nxt != o_pos);
            o_at_min  <= (pos_nxt == WIDTH'(MIN_VAL));
            o_at_max  <= (pos_nxt == WIDTH'(MAX_VAL));
            if (detent) o_dir <= i_cnt_cw;
            if (detent)           timer <= '0;
            else if (i_load)      timer <= WIN;
            else if (timer < WIN) timer <= timer + TW'(1);
            state <= state_nxt;
        end
    end
endmodule

// File: tb/tb_rotary_position_counter.sv
// Directed bench: saturating 8-bit counter, wrapping 0..9 counter and 9-bit clamped-load counter.
module tb_rotary_position_counter;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cnt = 1'b0;
    logic       cw  = 1'b0;
    logic       ld  = 1'b0;
    logic [8:0] lv  = '0;

    logic [7:0] pos0, pos1;
    logic [8:0] pos2;
    logic       chg0, dir0, mn0, mx0;
    logic       chg1, dir1, mn1, mx1;
    logic       chg2, dir2, mn2, mx2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rotary_position_counter #(.ACCEL_WINDOW(16)) d0 (
        .i_clk(clk), .i_rst(rst), .i_cnt(cnt), .i_cnt_cw(cw), .i_load(ld), .i_load_val(lv[7:0]),
        .o_pos(pos0), .o_changed(chg0), .o_dir(dir0), .o_at_min(mn0), .o_at_max(mx0));

    rotary_position_counter #(.MAX_VAL(9), .WRAP(1), .ACCEL_WINDOW(16)) d1 (
        .i_clk(clk), .i_rst(rst), .i_cnt(cnt), .i_cnt_cw(cw), .i_load(ld), .i_load_val(lv[7:0]),
        .o_pos(pos1), .o_changed(chg1), .o_dir(dir1), .o_at_min(mn1), .o_at_max(mx1));

    rotary_position_counter #(.WIDTH(9), .MAX_VAL(255), .ACCEL_WINDOW(16)) d2 (
        .i_clk(clk), .i_rst(rst), .i_cnt(cnt), .i_cnt_cw(cw), .i_load(ld), .i_load_val(lv),
        .o_pos(pos2), .o_changed(chg2), .o_dir(dir2), .o_at_min(mn2), .o_at_max(mx2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic detent(input logic dir);
        cnt = 1'b1; cw = dir;
        tick();
        cnt = 1'b0;
    endtask

    task automatic load(input logic [8:0] v);
        ld = 1'b1; lv = v;
        tick();
        ld = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (pos0 !== 8'd0) begin bad++; $display("FAIL reset_pos got=%0d exp=0", pos0); end
        total++; if ({chg0, dir0, mn0, mx0} !== 4'b0010) begin bad++; $display("FAIL reset_flags got=%b exp=0010", {chg0, dir0, mn0, mx0}); end
    endtask

    task automatic test_slow();
        for (int k = 1; k <= 3; k++) begin
            detent(1'b1);
            total++; if (pos0 !== 8'(k) || chg0 !== 1'b1) begin bad++; $display("FAIL slow_step%0d pos=%0d chg=%b exp=%0d/1", k, pos0, chg0, k); end
            tick();
            total++; if (chg0 !== 1'b0) begin bad++; $display("FAIL slow_pulse%0d chg=%b exp=0", k, chg0); end
            idle(38);
        end
        total++; if (dir0 !== 1'b1) begin bad++; $display("FAIL slow_dir got=%b exp=1", dir0); end
    endtask

    task automatic test_accel();
        logic [7:0] exp_p [4];
        exp_p[0] = 8'd11; exp_p[1] = 8'd15; exp_p[2] = 8'd19; exp_p[3] = 8'd23;
        load(9'd10);
        total++; if (pos0 !== 8'd10 || chg0 !== 1'b1) begin bad++; $display("FAIL accel_load pos=%0d chg=%b exp=10/1", pos0, chg0); end
        for (int k = 0; k < 4; k++) begin
            detent(1'b1);
            total++; if (pos0 !== exp_p[k]) begin bad++; $display("FAIL accel_step%0d got=%0d exp=%0d", k, pos0, exp_p[k]); end
            if (k < 3) idle(4);
        end
        idle(20);
        detent(1'b1);
        total++; if (pos0 !== 8'd24) begin bad++; $display("FAIL accel_slowdown got=%0d exp=24", pos0); end
    endtask

    task automatic test_saturate();
        load(9'd254);
        detent(1'b1);
        total++; if (pos0 !== 8'd255 || chg0 !== 1'b1 || mx0 !== 1'b1) begin bad++; $display("FAIL sat_hit pos=%0d chg=%b max=%b exp=255/1/1", pos0, chg0, mx0); end
        for (int k = 0; k < 2; k++) begin
            detent(1'b1);
            total++; if (pos0 !== 8'd255 || chg0 !== 1'b0 || mx0 !== 1'b1) begin bad++; $display("FAIL sat_hold%0d pos=%0d chg=%b max=%b exp=255/0/1", k, pos0, chg0, mx0); end
        end
        load(9'd1);
        detent(1'b0);
        total++; if (pos0 !== 8'd0 || mn0 !== 1'b1 || chg0 !== 1'b1 || dir0 !== 1'b0) begin bad++; $display("FAIL sat_min pos=%0d min=%b chg=%b dir=%b exp=0/1/1/0", pos0, mn0, chg0, dir0); end
        detent(1'b0);
        total++; if (pos0 !== 8'd0 || chg0 !== 1'b0) begin bad++; $display("FAIL sat_minhold pos=%0d chg=%b exp=0/0", pos0, chg0); end
    endtask

    task automatic test_wrap();
        load(9'd9);
        detent(1'b1);
        total++; if (pos1 !== 8'd0 || mn1 !== 1'b1) begin bad++; $display("FAIL wrap_up pos=%0d min=%b exp=0/1", pos1, mn1); end
        load(9'd7);
        detent(1'b1);
        total++; if (pos1 !== 8'd8) begin bad++; $display("FAIL wrap_pre got=%0d exp=8", pos1); end
        detent(1'b1);
        total++; if (pos1 !== 8'd2) begin bad++; $display("FAIL wrap_fast got=%0d exp=2", pos1); end
        load(9'd1);
        detent(1'b0);
        total++; if (pos1 !== 8'd0) begin bad++; $display("FAIL wrap_dn got=%0d exp=0", pos1); end
        idle(20);
        detent(1'b0);
        total++; if (pos1 !== 8'd9 || mx1 !== 1'b1) begin bad++; $display("FAIL wrap_under pos=%0d max=%b exp=9/1", pos1, mx1); end
        detent(1'b0);
        total++; if (pos1 !== 8'd5) begin bad++; $display("FAIL wrap_fastdn got=%0d exp=5", pos1); end
    endtask

    task automatic test_load();
        do_reset();
        load(9'd300);
        total++; if (pos2 !== 9'd255 || chg2 !== 1'b1 || mx2 !== 1'b1) begin bad++; $display("FAIL load_clamp pos=%0d chg=%b max=%b exp=255/1/1", pos2, chg2, mx2); end
        cnt = 1'b1; cw = 1'b0;
        load(9'd10);
        cnt = 1'b0;
        total++; if (pos2 !== 9'd10 || dir2 !== 1'b0) begin bad++; $display("FAIL load_vs_cnt pos=%0d dir=%b exp=10/0", pos2, dir2); end
        idle(2);
        detent(1'b0);
        total++; if (pos2 !== 9'd9) begin bad++; $display("FAIL load_next got=%0d exp=9", pos2); end
        load(9'd9);
        total++; if (chg2 !== 1'b0) begin bad++; $display("FAIL load_same chg=%b exp=0", chg2); end
    endtask

    task automatic test_back_to_back_reset();
        load(9'd100);
        detent(1'b1);
        total++; if (pos0 !== 8'd101 || chg0 !== 1'b1) begin bad++; $display("FAIL b2b_first pos=%0d chg=%b exp=101/1", pos0, chg0); end
        detent(1'b1);
        total++; if (pos0 !== 8'd105 || chg0 !== 1'b1) begin bad++; $display("FAIL b2b_second pos=%0d chg=%b exp=105/1", pos0, chg0); end
        rst = 1'b1; cnt = 1'b1; cw = 1'b1;
        tick();
        rst = 1'b0; cnt = 1'b0;
        total++; if (pos0 !== 8'd0 || mn0 !== 1'b1 || chg0 !== 1'b0) begin bad++; $display("FAIL b2b_rst pos=%0d min=%b chg=%b exp=0/1/0", pos0, mn0, chg0); end
        detent(1'b1);
        total++; if (pos0 !== 8'd1) begin bad++; $display("FAIL b2b_after got=%0d exp=1", pos0); end
    endtask

    initial begin
        test_reset();
        test_slow();
        test_accel();
        test_saturate();
        test_wrap();
        test_load();
        test_back_to_back_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
